// File: rtl/resource_arbiter_q.sv
// Queued resource arbiter: eligible requesters enter a FIFO of IDs (lowest index
// first, one per edge) and receive a single registered one-hot grant in queue order.
module resource_arbiter_q #(
  parameter int NREQ   = 4,
  parameter int QDEPTH = 4,
  parameter int IDW    = $clog2(NREQ + 1),
  localparam int CW    = $clog2(QDEPTH + 1),
  localparam int PW    = $clog2(QDEPTH)
) (
  input  logic            clock_i,
  input  logic            reset_ni,
  input  logic [NREQ-1:0] request_i,
  output logic [NREQ-1:0] grant_o,
  output logic            busy_o,
  output logic [CW-1:0]   q_count_o,
  output logic            q_full_o,
  output logic            q_overflow_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSIGN = 2'd1;
  localparam logic [1:0] SERVE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic            ovf_q, ovf_d;
  logic [IDW-1:0]  mem_q [QDEPTH];

  logic [NREQ-1:0][QDEPTH-1:0] slot_hit;
  logic [NREQ-1:0] in_queue;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] head_oh;
  logic [IDW-1:0]  head_id;
  logic [IDW-1:0]  enq_id;
  logic            any_elig;
  logic            head_req;
  logic            pop;
  logic            enq;
  logic            full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Popped slots are zeroed, so a plain ID match over all slots means "queued".
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    for (genvar gj = 0; gj < QDEPTH; gj++) begin : g_slot
      assign slot_hit[gi][gj] = (mem_q[gj] == IDW'(gi + 1));
    end
    assign in_queue[gi] = |slot_hit[gi];
  end

  assign eligible = request_i & ~grant_q & ~in_queue;
  assign head_id  = mem_q[head_q];
  assign full     = (count_q == CW'(QDEPTH));
  assign pop      = (state_q == ASSIGN);

  always_comb begin
    enq_id   = '0;
    any_elig = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        any_elig = 1'b1;
        enq_id   = IDW'(i + 1);
      end
    end
  end

  always_comb begin
    head_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      head_oh[i] = (head_id == IDW'(i + 1));
    end
  end

  assign head_req = |(head_oh & request_i);
  // A pop frees the slot this edge, so a full queue can still accept.
  assign enq      = any_elig && (!full || pop);

  always_comb begin
    count_d = count_q + CW'(enq) - CW'(pop);
    head_d  = pop ? ptr_inc(head_q) : head_q;
    tail_d  = enq ? ptr_inc(tail_q) : tail_q;
    ovf_d   = ovf_q | (any_elig && full && !pop);
    grant_d = grant_q;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_d != '0) state_d = ASSIGN;
      end
      ASSIGN: begin
        if (head_req) begin
          grant_d = head_oh;
          state_d = SERVE;
        end else begin
          state_d = (count_d != '0) ? ASSIGN : IDLE;
        end
      end
      SERVE: begin
        if (!(|(grant_q & request_i))) begin
          grant_d = '0;
          state_d = (count_d != '0) ? ASSIGN : IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ovf_q   <= ovf_d;
      if (pop) mem_q[head_q] <= '0;
      // Placed after the clear so a full-queue pop+enqueue on one slot keeps the new ID.
      if (enq) mem_q[tail_q] <= enq_id;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = |grant_q;
  assign q_count_o    = count_q;
  assign q_full_o     = full;
  assign q_overflow_o = ovf_q;

endmodule
